// File: rtl/logic4_pkg.sv
// Shared types for the 4-bit logic unit and its round-robin arbiter.
package logic4_pkg;

  typedef enum logic [1:0] {OP_NOT, OP_OR, OP_AND, OP_XOR} logic4_op_e;

  typedef enum logic {ST_EMPTY, ST_FULL} logic4_arb_state_e;

endpackage

// File: rtl/and4.sv
// 4-bit bitwise AND.
module and4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] y
);
  assign y = a & b;
endmodule

// File: rtl/logic4_alu.sv
// Combinational 4-bit logic unit: runs all four gates and selects one by opcode.
module logic4_alu
  import logic4_pkg::*;
(
  input  logic4_op_e op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] y
);
  logic [3:0] y_not, y_or, y_and, y_xor;

  not4 u_not (.a(a), .y(y_not));
  or4  u_or  (.a(a), .b(b), .y(y_or));
  and4 u_and (.a(a), .b(b), .y(y_and));
  xor4 u_xor (.a(a), .b(b), .y(y_xor));

  always_comb begin
    y = y_not;
    case (op)
      OP_NOT: y = y_not;
      OP_OR:  y = y_or;
      OP_AND: y = y_and;
      OP_XOR: y = y_xor;
    endcase
  end
endmodule

// File: rtl/not4.sv
// 4-bit bitwise inverter.
module not4 (
  input  logic [3:0] a,
  output logic [3:0] y
);
  assign y = ~a;
endmodule

// File: rtl/or4.sv
// 4-bit bitwise OR.
module or4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] y
);
  assign y = a | b;
endmodule

// File: rtl/xor4.sv
// 4-bit bitwise XOR.
module xor4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] y
);
  assign y = a ^ b;
endmodule

// File: rtl/logic4_arbiter.sv
// Round-robin arbiter sharing one logic4_alu among NUM_REQ requesters,
// with a single registered response slot tagged by requester ID.
//
// state    | meaning
// ST_EMPTY | response slot free, RSP_VALID=0
// ST_FULL  | slot holds an unconsumed result, RSP_VALID=1
module logic4_arbiter
  import logic4_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [NUM_REQ-1:0]     REQ_VALID,
  output logic [NUM_REQ-1:0]     REQ_READY,
  input  logic [2*NUM_REQ-1:0]   REQ_OP,
  input  logic [4*NUM_REQ-1:0]   REQ_A,
  input  logic [4*NUM_REQ-1:0]   REQ_B,
  output logic                   RSP_VALID,
  input  logic                   RSP_READY,
  output logic [3:0]             RSP_DATA,
  output logic [ID_W-1:0]        RSP_ID
);
  logic4_arb_state_e state;
  logic [ID_W-1:0]   pri;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic              found;
  int                idx;
  logic              can_accept;
  logic              xfer;
  logic4_op_e        sel_op;
  logic [3:0]        sel_a, sel_b, alu_y;

  // Reset cycles never accept, so a request is not lost to the reset.
  assign can_accept = RST_N && ((state == ST_EMPTY) || RSP_READY);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(pri) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && REQ_VALID[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = ID_W'(idx);
      end
    end
  end

  assign REQ_READY = gnt & {NUM_REQ{can_accept}};
  assign xfer      = |REQ_READY;

  always_comb begin
    sel_op = OP_NOT;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_op = logic4_op_e'(REQ_OP[2*i +: 2]);
        sel_a  = REQ_A[4*i +: 4];
        sel_b  = REQ_B[4*i +: 4];
      end
    end
  end

  logic4_alu u_alu (.op(sel_op), .a(sel_a), .b(sel_b), .y(alu_y));

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= ST_EMPTY;
      RSP_DATA <= '0;
      RSP_ID   <= '0;
      pri      <= '0;
    end else if (xfer) begin
      state    <= ST_FULL;
      RSP_DATA <= alu_y;
      RSP_ID   <= gnt_idx;
      pri      <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (state == ST_FULL && RSP_READY) begin
      state <= ST_EMPTY;
    end
  end

  assign RSP_VALID = (state == ST_FULL);
endmodule

// File: tb/tb_logic4_arbiter.sv
// Directed bench for logic4_arbiter: vector table on a 2-requester instance,
// plus a hand-written sequence on a 3-requester instance.
module tb_logic4_arbiter;
  import logic4_pkg::*;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // 2-requester instance
  logic       rst2;
  logic [1:0] valid2, ready2;
  logic [3:0] op2;
  logic [7:0] a2, b2;
  logic       rsp_valid2, rsp_ready2;
  logic [3:0] rsp_data2;
  logic [1:0] rsp_id2;

  logic4_arbiter #(.NUM_REQ(2), .ID_W(2)) dut2 (
    .CLK(CLK), .RST_N(rst2), .REQ_VALID(valid2), .REQ_READY(ready2),
    .REQ_OP(op2), .REQ_A(a2), .REQ_B(b2), .RSP_VALID(rsp_valid2),
    .RSP_READY(rsp_ready2), .RSP_DATA(rsp_data2), .RSP_ID(rsp_id2)
  );

  // 3-requester instance
  logic        rst3;
  logic [2:0]  valid3, ready3;
  logic [5:0]  op3;
  logic [11:0] a3, b3;
  logic        rsp_valid3, rsp_ready3;
  logic [3:0]  rsp_data3;
  logic [1:0]  rsp_id3;

  logic4_arbiter #(.NUM_REQ(3), .ID_W(2)) dut3 (
    .CLK(CLK), .RST_N(rst3), .REQ_VALID(valid3), .REQ_READY(ready3),
    .REQ_OP(op3), .REQ_A(a3), .REQ_B(b3), .RSP_VALID(rsp_valid3),
    .RSP_READY(rsp_ready3), .RSP_DATA(rsp_data3), .RSP_ID(rsp_id3)
  );

  typedef struct {
    logic       rst_n;
    logic [1:0] valid;
    logic       rsp_ready;
    logic [1:0] op0;
    logic [3:0] a0, b0;
    logic [1:0] op1;
    logic [3:0] a1, b1;
    logic [1:0] exp_ready;
    logic       exp_valid;
    logic [3:0] exp_data;
    logic [1:0] exp_id;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst_n, logic [1:0] valid, logic rsp_ready,
                              logic [1:0] op0, logic [3:0] a0, logic [3:0] b0,
                              logic [1:0] op1, logic [3:0] a1, logic [3:0] b1,
                              logic [1:0] exp_ready, logic exp_valid,
                              logic [3:0] exp_data, logic [1:0] exp_id);
    vec_t v;
    v.rst_n = rst_n; v.valid = valid; v.rsp_ready = rsp_ready;
    v.op0 = op0; v.a0 = a0; v.b0 = b0;
    v.op1 = op1; v.a1 = a1; v.b1 = b1;
    v.exp_ready = exp_ready; v.exp_valid = exp_valid;
    v.exp_data = exp_data; v.exp_id = exp_id;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    rst2 = 1'b0; valid2 = '0; op2 = '0; a2 = '0; b2 = '0; rsp_ready2 = 1'b0;
    rst3 = 1'b0; valid3 = '0; op3 = '0; a3 = '0; b3 = '0; rsp_ready3 = 1'b0;

    // reset, with requests pending: no ready during reset
    vecs.push_back(mk(0, 2'b11, 0, 2'd0, 4'h0, 4'h0, 2'd0, 4'h0, 4'h0, 2'b00, 0, 4'h0, 2'd0));
    // single OR from requester 0
    vecs.push_back(mk(1, 2'b01, 1, OP_OR, 4'hA, 4'h5, 2'd0, 4'h0, 4'h0, 2'b01, 1, 4'hF, 2'd0));
    // both valid, back-to-back alternating grants (pri=1 after the first grant)
    vecs.push_back(mk(1, 2'b11, 1, OP_AND, 4'hC, 4'hA, OP_XOR, 4'hF, 4'h3, 2'b10, 1, 4'hC, 2'd1));
    vecs.push_back(mk(1, 2'b11, 1, OP_AND, 4'hC, 4'hA, OP_XOR, 4'hF, 4'h3, 2'b01, 1, 4'h8, 2'd0));
    vecs.push_back(mk(1, 2'b11, 1, OP_AND, 4'hC, 4'hA, OP_XOR, 4'hF, 4'h3, 2'b10, 1, 4'hC, 2'd1));
    vecs.push_back(mk(1, 2'b11, 1, OP_AND, 4'hC, 4'hA, OP_XOR, 4'hF, 4'h3, 2'b01, 1, 4'h8, 2'd0));
    // NOT 6 then 3 stalled cycles with requester 0 waiting and changing operands
    vecs.push_back(mk(1, 2'b10, 1, OP_AND, 4'hC, 4'hA, OP_NOT, 4'h6, 4'h0, 2'b10, 1, 4'h9, 2'd1));
    vecs.push_back(mk(1, 2'b01, 0, OP_AND, 4'hF, 4'hF, OP_NOT, 4'h6, 4'h0, 2'b00, 1, 4'h9, 2'd1));
    vecs.push_back(mk(1, 2'b01, 0, OP_OR,  4'h0, 4'h8, OP_NOT, 4'h6, 4'h0, 2'b00, 1, 4'h9, 2'd1));
    vecs.push_back(mk(1, 2'b01, 0, OP_XOR, 4'h8, 4'h1, OP_NOT, 4'h6, 4'h0, 2'b00, 1, 4'h9, 2'd1));
    // drain and refill in the same cycle
    vecs.push_back(mk(1, 2'b01, 1, OP_XOR, 4'h3, 4'h5, OP_NOT, 4'h6, 4'h0, 2'b01, 1, 4'h6, 2'd0));
    // drain with nothing pending: data/id keep last values; then idle
    vecs.push_back(mk(1, 2'b00, 1, OP_XOR, 4'h3, 4'h5, OP_NOT, 4'h6, 4'h0, 2'b00, 0, 4'h6, 2'd0));
    vecs.push_back(mk(1, 2'b00, 0, OP_XOR, 4'h3, 4'h5, OP_NOT, 4'h6, 4'h0, 2'b00, 0, 4'h6, 2'd0));
    // five transfers from requester 1 alone
    for (int i = 1; i <= 5; i++)
      vecs.push_back(mk(1, 2'b10, 1, OP_OR, 4'h1, 4'h2, OP_AND, 4'hF, 4'(i), 2'b10, 1, 4'(i), 2'd1));
    // both valid: requester 0 first
    vecs.push_back(mk(1, 2'b11, 1, OP_OR, 4'h1, 4'h2, OP_AND, 4'hF, 4'h5, 2'b01, 1, 4'h3, 2'd0));
    vecs.push_back(mk(1, 2'b11, 1, OP_OR, 4'h1, 4'h2, OP_AND, 4'hF, 4'h5, 2'b10, 1, 4'h5, 2'd1));
    // hold full, reset mid-operation, then requester 0 has priority again
    vecs.push_back(mk(1, 2'b11, 0, OP_OR, 4'h1, 4'h2, OP_AND, 4'hF, 4'h5, 2'b00, 1, 4'h5, 2'd1));
    vecs.push_back(mk(0, 2'b11, 0, OP_OR, 4'h1, 4'h2, OP_AND, 4'hF, 4'h5, 2'b00, 0, 4'h0, 2'd0));
    vecs.push_back(mk(1, 2'b11, 0, OP_OR, 4'h1, 4'h2, OP_AND, 4'hF, 4'h5, 2'b01, 1, 4'h3, 2'd0));

    @(posedge CLK);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      rst2       = vecs[i].rst_n;
      valid2     = vecs[i].valid;
      rsp_ready2 = vecs[i].rsp_ready;
      op2        = {vecs[i].op1, vecs[i].op0};
      a2         = {vecs[i].a1, vecs[i].a0};
      b2         = {vecs[i].b1, vecs[i].b0};
      #1;
      chk($sformatf("v%0d ready", i), 32'(ready2), 32'(vecs[i].exp_ready));
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d rsp_valid", i), 32'(rsp_valid2), 32'(vecs[i].exp_valid));
      chk($sformatf("v%0d rsp_data", i), 32'(rsp_data2), 32'(vecs[i].exp_data));
      chk($sformatf("v%0d rsp_id", i), 32'(rsp_id2), 32'(vecs[i].exp_id));
    end

    // three requesters, all valid, consumer toggling ready
    begin
      logic [2:0] exp_rdy[8] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000};
      logic [3:0] exp_d[8]   = '{4'hF, 4'hF, 4'h3, 4'h3, 4'h6, 4'h6, 4'hF, 4'hF};
      logic [1:0] exp_i[8]   = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0};
      op3    = {OP_XOR, OP_OR, OP_NOT};
      a3     = {4'h7, 4'h1, 4'h0};
      b3     = {4'h1, 4'h2, 4'h0};
      valid3 = 3'b111;
      rst3   = 1'b0;
      #1;
      chk("r3 reset ready", 32'(ready3), 32'h0);
      @(posedge CLK);
      #1;
      chk("r3 reset rsp_valid", 32'(rsp_valid3), 32'h0);
      rst3 = 1'b1;
      for (int c = 0; c < 8; c++) begin
        rsp_ready3 = (c % 2 == 0);
        #1;
        chk($sformatf("r3 c%0d ready", c), 32'(ready3), 32'(exp_rdy[c]));
        @(posedge CLK);
        #1;
        chk($sformatf("r3 c%0d rsp_valid", c), 32'(rsp_valid3), 32'h1);
        chk($sformatf("r3 c%0d rsp_data", c), 32'(rsp_data3), 32'(exp_d[c]));
        chk($sformatf("r3 c%0d rsp_id", c), 32'(rsp_id3), 32'(exp_i[c]));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
